// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive frame controller (optional error counter: UART_RX_ERR_CNT_EN)
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic               sampled_bit,
    output logic               deser_en,
    output logic [3:0]         bit_cnt,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               busy,
    output logic [7:0]         ERR_CNT
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_8   = PRESC_W'(8);
    localparam logic [PRESC_W-1:0] PRESC_16  = PRESC_W'(16);
    localparam logic [PRESC_W-1:0] PRESC_32  = PRESC_W'(32);
    localparam logic [3:0]         LAST_DATA = 4'(DATA_WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] presc_lat;
    logic [PRESC_W-1:0] presc_dec;
    logic [PRESC_W-1:0] half;
    logic               par_en_lat;
    logic               par_typ_lat;
    logic               par_acc;
    logic               frame_err;
    logic [2:0]         samples;
    logic               start_det;
    logic               bit_end;
    logic               vote_pt;
    logic               vote;
    logic               start_glitch;
    logic               par_fail;
    logic               stop_fail;
    logic               frame_ok;

    // Unsupported oversampling ratios fall back to 8.
    assign presc_dec = ((Prescale == PRESC_16) || (Prescale == PRESC_32)) ? Prescale : PRESC_8;

    assign half      = presc_lat >> 1;
    assign start_det = (state == IDLE) && !RX_IN;
    assign bit_end   = (state != IDLE) && (edge_cnt == presc_lat - PRESC_W'(1));
    assign vote_pt   = (state != IDLE) && (edge_cnt == half + PRESC_W'(2));
    assign vote      = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
    assign busy      = (state != IDLE);

    assign start_glitch = (state == START)  && bit_end && sampled_bit;
    assign par_fail     = (state == PARITY) && bit_end && (sampled_bit != (par_acc ^ par_typ_lat));
    assign stop_fail    = (state == STOP)   && bit_end && !sampled_bit;
    assign frame_ok     = (state == STOP)   && bit_end && sampled_bit && !frame_err;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_det) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (start_glitch) begin
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt == LAST_DATA)) begin
                    state_nxt = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            edge_cnt    <= '0;
            presc_lat   <= PRESC_8;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
            par_acc     <= 1'b0;
            frame_err   <= 1'b0;
            samples     <= '0;
            sampled_bit <= 1'b0;
            deser_en    <= 1'b0;
            bit_cnt     <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            deser_en   <= 1'b0;
            data_valid <= frame_ok;
            par_err    <= par_fail;
            stp_err    <= stop_fail;
            if (state == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
                if (start_det) begin
                    presc_lat   <= presc_dec;
                    par_en_lat  <= PAR_EN;
                    par_typ_lat <= PAR_TYP;
                    par_acc     <= 1'b0;
                    frame_err   <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_W'(1);
                if (edge_cnt == half - PRESC_W'(1)) begin
                    samples[0] <= RX_IN;
                end
                if (edge_cnt == half) begin
                    samples[1] <= RX_IN;
                end
                if (edge_cnt == half + PRESC_W'(1)) begin
                    samples[2] <= RX_IN;
                end
                // The strobe lands in the same cycle the voted data bit becomes visible.
                if (vote_pt) begin
                    sampled_bit <= vote;
                    if (state == DATA) begin
                        deser_en <= 1'b1;
                        par_acc  <= par_acc ^ vote;
                    end
                end
                if (bit_end) begin
                    bit_cnt <= (state_nxt == IDLE) ? 4'd0 : bit_cnt + 4'd1;
                end
                if (par_fail) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            err_cnt_q <= 8'd0;
        end else if ((start_glitch || par_fail || stop_fail) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign ERR_CNT = err_cnt_q;
`else
    assign ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - directed bench for uart_rx_fsm
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       deser_en;
    logic [3:0] bit_cnt;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;
    logic [7:0] ERR_CNT;

    uart_rx_fsm #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK(CLK), .RST_n(RST_n), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
        .deser_en(deser_en), .bit_cnt(bit_cnt), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err), .busy(busy), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          deser_total = 0;
    int          dv_total = 0;
    int          pe_total = 0;
    int          se_total = 0;
    int          dv_cyc = -1;
    int          prev_dv_cyc = -1;
    int          pe_cyc = -1;
    int          se_cyc = -1;
    int          busy_rise_cyc = -1;
    logic        busy_d = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [31:0] bc_hist = 32'h0;

    always @(negedge CLK) begin
        if (deser_en) begin
            deser_total = deser_total + 1;
            rx_byte = {sampled_bit, rx_byte[7:1]};
            bc_hist = {bc_hist[27:0], bit_cnt};
        end
        if (data_valid) begin
            dv_total = dv_total + 1;
            prev_dv_cyc = dv_cyc;
            dv_cyc = cyc;
        end
        if (par_err) begin
            pe_total = pe_total + 1;
            pe_cyc = cyc;
        end
        if (stp_err) begin
            se_total = se_total + 1;
            se_cyc = cyc;
        end
        if (busy && !busy_d) busy_rise_cyc = cyc;
        busy_d = busy;
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int err_exp = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic bump_err();
`ifdef UART_RX_ERR_CNT_EN
        err_exp++;
`endif
    endtask

    // Drives one line-timed frame; t is the edge at which the start bit is first seen.
    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pbit,
                              input bit stopb, input int p, output int t);
        @(posedge CLK); #1;
        RX_IN = 1'b0;
        t = cyc + 1;
        repeat (p) @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            #1 RX_IN = d[i];
            repeat (p) @(posedge CLK);
        end
        if (pe) begin
            #1 RX_IN = pbit;
            repeat (p) @(posedge CLK);
        end
        #1 RX_IN = stopb;
        repeat (p) @(posedge CLK);
        #1 RX_IN = 1'b1;
    endtask

    int t, t2, b_des, b_dv, b_pe, b_se;

    initial begin
        RST_n = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK); #1;
        check("rst_sampled_bit", 32'(sampled_bit), 0);
        check("rst_deser_en", 32'(deser_en), 0);
        check("rst_bit_cnt", 32'(bit_cnt), 0);
        check("rst_pulses", {29'd0, data_valid, par_err, stp_err}, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err_cnt", 32'(ERR_CNT), 0);
        RST_n = 1'b1;
        repeat (2) @(posedge CLK);

        // 1: P=8, no parity, 0xA5
        b_des = deser_total; b_dv = dv_total; b_pe = pe_total; b_se = se_total;
        send_frame(8'hA5, 0, 0, 1, 8, t);
        repeat (4) @(posedge CLK); #1;
        check("t1_detect", 32'(busy_rise_cyc), 32'(t));
        check("t1_deser_count", 32'(deser_total - b_des), 8);
        check("t1_byte", 32'(rx_byte), 32'hA5);
        check("t1_bit_cnt_seq", bc_hist, 32'h12345678);
        check("t1_dv_count", 32'(dv_total - b_dv), 1);
        check("t1_dv_time", 32'(dv_cyc), 32'(t + 80));
        check("t1_no_err", 32'((pe_total - b_pe) + (se_total - b_se)), 0);
        check("t1_busy_after", 32'(busy), 0);

        // 2: P=16, even parity, good then bad parity bit
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        b_dv = dv_total; b_pe = pe_total;
        send_frame(8'h3C, 1, 0, 1, 16, t);
        repeat (4) @(posedge CLK); #1;
        check("t2_byte", 32'(rx_byte), 32'h3C);
        check("t2_dv_time", 32'(dv_cyc), 32'(t + 176));
        check("t2_no_par_err", 32'(pe_total - b_pe), 0);
        b_dv = dv_total;
        send_frame(8'h3C, 1, 1, 1, 16, t);
        repeat (4) @(posedge CLK); #1;
        bump_err();
        check("t2_par_err_count", 32'(pe_total - b_pe), 1);
        check("t2_par_err_time", 32'(pe_cyc), 32'(t + 160));
        check("t2_no_dv", 32'(dv_total - b_dv), 0);
        check("t2_err_cnt", 32'(ERR_CNT), 32'(err_exp));

        // 3: two-cycle glitch at P=8
        Prescale = 6'd8; PAR_EN = 1'b0;
        b_des = deser_total;
        @(posedge CLK); #1;
        RX_IN = 1'b0;
        t = cyc + 1;
        repeat (2) @(posedge CLK); #1;
        RX_IN = 1'b1;
        repeat (7) @(negedge CLK);
        check("t3_cycle_ref", 32'(cyc), 32'(t + 7));
        check("t3_busy_before_end", 32'(busy), 1);
        @(negedge CLK);
        bump_err();
        check("t3_busy_at_end", 32'(busy), 0);
        check("t3_no_deser", 32'(deser_total - b_des), 0);
        check("t3_err_cnt", 32'(ERR_CNT), 32'(err_exp));

        // 4: stop bit low
        b_dv = dv_total; b_se = se_total;
        send_frame(8'h5A, 0, 0, 0, 8, t);
        repeat (4) @(posedge CLK); #1;
        bump_err();
        check("t4_stp_err_count", 32'(se_total - b_se), 1);
        check("t4_stp_err_time", 32'(se_cyc), 32'(t + 80));
        check("t4_no_dv", 32'(dv_total - b_dv), 0);
        check("t4_err_cnt", 32'(ERR_CNT), 32'(err_exp));

        // 5: back-to-back frames at P=32 with parity
        Prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        b_des = deser_total; b_dv = dv_total;
        send_frame(8'h00, 1, 0, 1, 32, t);
        send_frame(8'hFF, 1, 0, 1, 32, t2);
        repeat (4) @(posedge CLK); #1;
        check("t5_dv_count", 32'(dv_total - b_dv), 2);
        check("t5_deser_count", 32'(deser_total - b_des), 16);
        check("t5_dv1_time", 32'(prev_dv_cyc), 32'(t + 352));
        check("t5_second_detect", 32'(busy_rise_cyc), 32'(t + 353));
        check("t5_dv2_time", 32'(dv_cyc), 32'(t + 353 + 352));
        check("t5_byte", 32'(rx_byte), 32'hFF);

        // 6: reset during data bit 4, then a clean frame with Prescale=5
        Prescale = 6'd8; PAR_EN = 1'b0;
        @(posedge CLK); #1;
        RX_IN = 1'b0;
        repeat (8) @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            #1 RX_IN = i[0];
            repeat (8) @(posedge CLK);
        end
        #1 RX_IN = 1'b0;
        repeat (4) @(posedge CLK); #1;
        check("t6_mid_bit_cnt", 32'(bit_cnt), 4);
        b_dv = dv_total; b_pe = pe_total; b_se = se_total;
        RST_n = 1'b0; RX_IN = 1'b1;
        @(posedge CLK); #1;
        RST_n = 1'b1;
        err_exp = 0;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_bit_cnt", 32'(bit_cnt), 0);
        check("t6_rst_outs", {27'd0, sampled_bit, deser_en, data_valid, par_err, stp_err}, 0);
        check("t6_rst_err_cnt", 32'(ERR_CNT), 0);
        repeat (20) @(posedge CLK); #1;
        check("t6_no_pulses", 32'((dv_total - b_dv) + (pe_total - b_pe) + (se_total - b_se)), 0);
        Prescale = 6'd5;
        send_frame(8'hC3, 0, 0, 1, 8, t);
        repeat (4) @(posedge CLK); #1;
        check("t6_dv_count", 32'(dv_total - b_dv), 1);
        check("t6_dv_time", 32'(dv_cyc), 32'(t + 80));
        check("t6_byte", 32'(rx_byte), 32'hC3);
        check("t6_err_cnt_end", 32'(ERR_CNT), 32'(err_exp));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
